// File: rtl/col_gram_calc_pkg.sv
// Shared SOML decoder definitions: element geometry, accumulator width,
// Gram-stage FSM states and small arithmetic/slicing helpers.
package soml_pkg;

  localparam int DW = 16;          // signed width of one real/imag element
  localparam int NE = 4;           // elements per channel column
  localparam int AW = 2 * DW + 3;  // accumulator/result width, holds 2^33
  localparam int SW = $clog2(NE);      // element select width
  localparam int IW = $clog2(NE + 1);  // element counter width (may reach NE)

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } gram_state_e;

  // Element k of a packed column word; k = 0 sits in the MSBs.
  function automatic logic signed [DW-1:0] elem_slice(
    input logic [NE*DW-1:0] word,
    input logic [SW-1:0]    k
  );
    return word[NE*DW-1-int'(k)*DW -: DW];
  endfunction

  // Full signed DW x DW product at 2*DW bits.
  function automatic logic signed [2*DW-1:0] smul(
    input logic signed [DW-1:0] a,
    input logic signed [DW-1:0] b
  );
    logic signed [2*DW-1:0] ax;
    logic signed [2*DW-1:0] bx;
    ax = {{DW{a[DW-1]}}, a};
    bx = {{DW{b[DW-1]}}, b};
    return ax * bx;
  endfunction

  // Sign-extend a product to accumulator width.
  function automatic logic signed [AW-1:0] sext_prod(
    input logic signed [2*DW-1:0] p
  );
    return {{(AW - 2 * DW){p[2*DW-1]}}, p};
  endfunction

endpackage

// File: rtl/col_gram_calc_if.sv
// Bus between the column collector and the Gram calculator.
// Handshake: start is a one-cycle request whose column words are valid only
// in that cycle; it is accepted only when state is IDLE (busy low, or the
// done cycle). done is a one-cycle pulse marking that all four results were
// updated together; results hold until the next done. state mirrors the FSM.
interface col_gram_calc_if;
  import soml_pkg::*;

  logic                 start;
  logic [NE*DW-1:0]     col0_r;
  logic [NE*DW-1:0]     col0_i;
  logic [NE*DW-1:0]     col1_r;
  logic [NE*DW-1:0]     col1_i;
  logic signed [AW-1:0] norm0;
  logic signed [AW-1:0] norm1;
  logic signed [AW-1:0] cross_r;
  logic signed [AW-1:0] cross_i;
  logic                 busy;
  logic                 done;
  gram_state_e          state;

  modport master (
    output start, col0_r, col0_i, col1_r, col1_i,
    input  norm0, norm1, cross_r, cross_i, busy, done, state
  );

  modport slave (
    input  start, col0_r, col0_i, col1_r, col1_i,
    output norm0, norm1, cross_r, cross_i, busy, done, state
  );

endinterface

// File: rtl/col_gram_calc_cmac.sv
// cmac_acc: accumulates conj(a)*b for one element pair per enabled cycle.
// Optional macro GRAM_MULT_PIPE_EN inserts a register after the multipliers.
module cmac_acc
  import soml_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr_i,
  input  logic                 en_i,
  input  logic signed [DW-1:0] a_r_i,
  input  logic signed [DW-1:0] a_i_i,
  input  logic signed [DW-1:0] b_r_i,
  input  logic signed [DW-1:0] b_i_i,
  output logic signed [AW-1:0] acc_r_o,
  output logic signed [AW-1:0] acc_i_o
);

  logic signed [AW-1:0] term_r;
  logic signed [AW-1:0] term_i;
  logic signed [AW-1:0] add_r;
  logic signed [AW-1:0] add_i;
  logic                 add_en;
  logic signed [AW-1:0] acc_r_q;
  logic signed [AW-1:0] acc_i_q;

  // conj(a)*b: re = ar*br + ai*bi, im = ar*bi - ai*br, summed at AW bits
  always_comb begin
    term_r = sext_prod(smul(a_r_i, b_r_i)) + sext_prod(smul(a_i_i, b_i_i));
    term_i = sext_prod(smul(a_r_i, b_i_i)) - sext_prod(smul(a_i_i, b_r_i));
  end

`ifdef GRAM_MULT_PIPE_EN
  logic signed [AW-1:0] term_r_q;
  logic signed [AW-1:0] term_i_q;
  logic                 vld_q;

  // Product register; the valid bit tracks which stage holds a real element
  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      term_r_q <= '0;
      term_i_q <= '0;
      vld_q    <= 1'b0;
    end else begin
      term_r_q <= term_r;
      term_i_q <= term_i;
      vld_q    <= en_i;
    end
  end

  assign add_r  = term_r_q;
  assign add_i  = term_i_q;
  assign add_en = vld_q;
`else
  assign add_r  = term_r;
  assign add_i  = term_i;
  assign add_en = en_i;
`endif

  // Accumulators: cleared at start acceptance, summed while elements flow
  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      acc_r_q <= '0;
      acc_i_q <= '0;
    end else if (add_en) begin
      acc_r_q <= acc_r_q + add_r;
      acc_i_q <= acc_i_q + add_i;
    end
  end

  assign acc_r_o = acc_r_q;
  assign acc_i_o = acc_i_q;

endmodule

// File: rtl/col_gram_calc.sv
// col_gram_calc: 2x2 Gram terms ||h0||^2, ||h1||^2 and h0^H*h1 computed one
// element per cycle. Optional macro GRAM_MULT_PIPE_EN adds a multiplier
// register stage, lengthening CALC by one cycle.
module col_gram_calc
  import soml_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  col_gram_calc_if.slave bus
);

  localparam logic [IW-1:0] NE_I = IW'(NE);
`ifdef GRAM_MULT_PIPE_EN
  localparam logic [IW-1:0] LAST_I = IW'(NE);      // one extra cycle to drain
`else
  localparam logic [IW-1:0] LAST_I = IW'(NE - 1);
`endif

  gram_state_e          state_q;
  logic [IW-1:0]        idx_q;
  logic [NE*DW-1:0]     c0r_q, c0i_q, c1r_q, c1i_q;
  logic signed [AW-1:0] norm0_q, norm1_q, cross_r_q, cross_i_q;
  logic                 busy_q;
  logic                 done_q;

  logic                 clr;
  logic                 en;
  logic signed [DW-1:0] e0r, e0i, e1r, e1i;
  logic signed [AW-1:0] acc_re [3];
  logic signed [AW-1:0] acc_im [3];

  // Clear on acceptance, feed one element per CALC cycle while idx < NE
  always_comb begin
    clr = (state_q == IDLE) && bus.start;
    en  = (state_q == CALC) && (idx_q < NE_I);
    e0r = elem_slice(c0r_q, idx_q[SW-1:0]);
    e0i = elem_slice(c0i_q, idx_q[SW-1:0]);
    e1r = elem_slice(c1r_q, idx_q[SW-1:0]);
    e1i = elem_slice(c1i_q, idx_q[SW-1:0]);
  end

  cmac_acc u_norm0 (
    .clk(clk), .rst(rst), .clr_i(clr), .en_i(en),
    .a_r_i(e0r), .a_i_i(e0i), .b_r_i(e0r), .b_i_i(e0i),
    .acc_r_o(acc_re[0]), .acc_i_o(acc_im[0])
  );

  cmac_acc u_norm1 (
    .clk(clk), .rst(rst), .clr_i(clr), .en_i(en),
    .a_r_i(e1r), .a_i_i(e1i), .b_r_i(e1r), .b_i_i(e1i),
    .acc_r_o(acc_re[1]), .acc_i_o(acc_im[1])
  );

  cmac_acc u_cross (
    .clk(clk), .rst(rst), .clr_i(clr), .en_i(en),
    .a_r_i(e0r), .a_i_i(e0i), .b_r_i(e1r), .b_i_i(e1i),
    .acc_r_o(acc_re[2]), .acc_i_o(acc_im[2])
  );

  // Control FSM: capture columns, step through elements, publish results
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      c0r_q     <= '0;
      c0i_q     <= '0;
      c1r_q     <= '0;
      c1i_q     <= '0;
      norm0_q   <= '0;
      norm1_q   <= '0;
      cross_r_q <= '0;
      cross_i_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            c0r_q   <= bus.col0_r;
            c0i_q   <= bus.col0_i;
            c1r_q   <= bus.col1_r;
            c1i_q   <= bus.col1_i;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= CALC;
          end
        end
        CALC: begin
          idx_q <= idx_q + IW'(1);
          if (idx_q == LAST_I) state_q <= DONE;
        end
        DONE: begin
          norm0_q   <= acc_re[0];
          norm1_q   <= acc_re[1];
          cross_r_q <= acc_re[2];
          cross_i_q <= acc_im[2];
          done_q    <= 1'b1;
          busy_q    <= 1'b0;
          idx_q     <= '0;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.norm0   = norm0_q;
  assign bus.norm1   = norm1_q;
  assign bus.cross_r = cross_r_q;
  assign bus.cross_i = cross_i_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.state   = state_q;

endmodule

// File: tb/tb_col_gram_calc.sv
// Directed bench for col_gram_calc; honours GRAM_MULT_PIPE_EN for latency.
module tb_col_gram_calc;
  import soml_pkg::*;

`ifdef GRAM_MULT_PIPE_EN
  localparam int LAT = NE + 2;
`else
  localparam int LAT = NE + 1;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  col_gram_calc_if bus();

  col_gram_calc dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_vec    = 0;
  int n_err    = 0;
  int done_cnt = 0;

  always @(negedge clk) if (bus.done === 1'b1) done_cnt++;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [NE*DW-1:0] pack4(
    input logic signed [DW-1:0] e0, input logic signed [DW-1:0] e1,
    input logic signed [DW-1:0] e2, input logic signed [DW-1:0] e3);
    return {e0, e1, e2, e3};
  endfunction

  // Column inputs are only valid in the start cycle: scramble them afterwards
  task automatic scramble();
    bus.col0_r = {$urandom, $urandom};
    bus.col0_i = {$urandom, $urandom};
    bus.col1_r = {$urandom, $urandom};
    bus.col1_i = {$urandom, $urandom};
  endtask

  task automatic drive_cols(input logic [NE*DW-1:0] c0r, input logic [NE*DW-1:0] c0i,
                            input logic [NE*DW-1:0] c1r, input logic [NE*DW-1:0] c1i);
    bus.col0_r = c0r;
    bus.col0_i = c0i;
    bus.col1_r = c1r;
    bus.col1_i = c1i;
  endtask

  task automatic apply_start(input logic [NE*DW-1:0] c0r, input logic [NE*DW-1:0] c0i,
                             input logic [NE*DW-1:0] c1r, input logic [NE*DW-1:0] c1i);
    drive_cols(c0r, c0i, c1r, c1i);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    scramble();
  endtask

  // Edges from now until done is seen (-1 if the budget runs out)
  task automatic wait_done(output int lat);
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic chk_res(input string tag, input logic signed [63:0] n0,
                         input logic signed [63:0] n1, input logic signed [63:0] cr,
                         input logic signed [63:0] ci);
    chk({tag, "_norm0"},   bus.norm0,   n0);
    chk({tag, "_norm1"},   bus.norm1,   n1);
    chk({tag, "_cross_r"}, bus.cross_r, cr);
    chk({tag, "_cross_i"}, bus.cross_i, ci);
  endtask

  // directed stimulus
  initial begin
    logic [NE*DW-1:0] ones, zero, a0r, a0i, a1r, a1i, mn;
    int lat;
    int d0;

    ones = pack4(16'sd1, 16'sd1, 16'sd1, 16'sd1);
    zero = '0;
    a0r  = pack4(16'sd1, 16'sd3, 16'sd5, 16'sd7);
    a0i  = pack4(16'sd2, 16'sd4, 16'sd6, 16'sd8);
    a1r  = pack4(-16'sd1, -16'sd1, -16'sd1, -16'sd1);
    a1i  = ones;
    mn   = pack4(16'sh8000, 16'sh8000, 16'sh8000, 16'sh8000);

    rst       = 1'b1;
    bus.start = 1'b0;
    drive_cols(zero, zero, zero, zero);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", bus.state, IDLE);
    chk("rst_busy",  bus.busy,  0);
    chk("rst_done",  bus.done,  0);
    chk_res("rst", 0, 0, 0, 0);
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;

    // unit: h0 all (1,0), h1 all (0,1)
    apply_start(ones, zero, zero, ones);
    chk("unit_busy_hi", bus.busy, 1);
    wait_done(lat);
    chk("unit_lat", lat, LAT);
    chk("unit_busy_lo", bus.busy, 0);
    chk_res("unit", 4, 4, 0, 4);
    @(posedge clk); #1;
    chk("unit_done_drop", bus.done, 0);

    // ordering / sign
    apply_start(a0r, a0i, a1r, a1i);
    wait_done(lat);
    chk("ord_lat", lat, LAT);
    chk_res("ord", 204, 8, 4, 36);
    repeat (3) @(posedge clk);
    #1;
    chk_res("ord_hold", 204, 8, 4, 36);

    // extreme values, no wrap
    apply_start(mn, mn, mn, mn);
    wait_done(lat);
    chk("ext_lat", lat, LAT);
    chk_res("ext", 64'sd8589934592, 64'sd8589934592, 64'sd8589934592, 0);
    repeat (2) @(posedge clk);
    #1;

    // start while busy is ignored
    d0 = done_cnt;
    apply_start(a0r, a0i, a1r, a1i);
    @(posedge clk); #1;
    drive_cols(ones, zero, zero, ones);
    bus.start = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    scramble();
    wait_done(lat);
    chk("busy_lat", lat, LAT - 3);
    chk_res("busy", 204, 8, 4, 36);

    // back-to-back: start in the done cycle
    apply_start(mn, mn, mn, mn);
    chk("b2b_one_done", done_cnt - d0, 1);
    chk("b2b_busy", bus.busy, 1);
    wait_done(lat);
    chk("b2b_lat", lat, LAT);
    chk_res("b2b", 64'sd8589934592, 64'sd8589934592, 64'sd8589934592, 0);
    @(posedge clk); #1;
    chk("b2b_two_done", done_cnt - d0, 2);

    // reset mid-operation at idx 2
    apply_start(ones, zero, zero, ones);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mid_state", bus.state, CALC);
    d0  = done_cnt;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_state", bus.state, IDLE);
    chk("mid_rst_busy",  bus.busy,  0);
    chk("mid_rst_done",  bus.done,  0);
    chk_res("mid_rst", 0, 0, 0, 0);
    repeat (8) @(posedge clk);
    #1;
    chk("mid_no_done", done_cnt - d0, 0);
    apply_start(a0r, a0i, a1r, a1i);
    wait_done(lat);
    chk("post_lat", lat, LAT);
    chk_res("post", 204, 8, 4, 36);

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/col_gram_calc.md
Name: col_gram_calc

Overview:
- Downstream consumer of the column-collector stage in the SOML decoder.
- Takes two complex 4-element channel columns h0 and h1 (packed 4x16-bit real and imaginary words) on a start pulse.
- Computes the 2x2 Gram terms ||h0||^2, ||h1||^2 and h0^H*h1 with one shared multiplier set, one element per cycle.
- Results feed the ML metric / QR stage.

Parameters:
- DW, 16: signed width of each real/imag element.
- NE, 4: elements per column; packed inputs are NE*DW bits.
- AW, 2*DW+3: width of every accumulator and result, signed two's complement.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse: column inputs valid this cycle
- col0_r  in  NE*DW  h0 real parts; element k at bits [NE*DW-1-k*DW -: DW], k=0 in MSBs
- col0_i  in  NE*DW  h0 imaginary parts, same packing
- col1_r  in  NE*DW  h1 real parts, same packing
- col1_i  in  NE*DW  h1 imaginary parts, same packing
- norm0  out  AW  sum over k of r0^2 + i0^2
- norm1  out  AW  sum over k of r1^2 + i1^2
- cross_r  out  AW  Re(h0^H h1) = sum of r0*r1 + i0*i1
- cross_i  out  AW  Im(h0^H h1) = sum of r0*i1 - i0*r1
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse: outputs updated

Behaviour:
- Single clock domain. Reset is synchronous, active-high.
- Reset: FSM=IDLE, idx=0, accumulators=0, all result outputs=0, busy=0, done=0.
- Inputs are guaranteed valid only in the start cycle. On acceptance, all four packed words are captured into internal registers.
- FSM states:
  - IDLE: start=1 captures inputs, clears accumulators, idx=0, goes to CALC. busy=1 from the next cycle.
  - CALC: each clock multiplies element idx (signed DWxDW -> 2*DW), sign-extends to AW and accumulates into the four accumulators; idx increments. After the idx=NE-1 update, goes to DONE.
  - DONE: registers the accumulators onto the outputs, pulses done=1 for one cycle, clears busy, returns to IDLE.
- Latency: start sampled at edge t; done and new results visible after edge t+NE+1 (t+5 at default).
- Outputs hold their value until the next done. They are never partially updated.
- start while busy (CALC/DONE) is ignored, with no effect on the computation in flight.
- start in the cycle where done=1 (FSM already IDLE) is accepted, giving back-to-back operation with a period of NE+2 cycles.
- Arithmetic:
  - Products are signed 2*DW bits.
  - Each two-term sum/difference is computed at AW bits. AW holds the worst case (-2^15)^2*2*4 = 2^33 with no overflow, so no saturation is needed.
  - idx wraps only via the return to IDLE, never modulo.
- rst mid-operation aborts immediately to the reset state; done does not pulse.

Optional Feature:
- Macro GRAM_MULT_PIPE_EN.
- Defined: a register stage follows the multipliers. Accumulation lags by one cycle, CALC lasts NE+1 cycles, and latency becomes t+NE+2 (6 at default). done timing, busy length and the back-to-back period (NE+3) grow by one accordingly.
- Undefined: products feed the accumulators combinationally, with latency as above.

Decomposition:
- Package soml_pkg holds:
  - DW, NE and AW constants.
  - FSM state typedef (IDLE/CALC/DONE).
  - Element-slice helper function, shared with the column collector.
- One natural sub-module, cmac_acc: a complex multiply-accumulate of one element pair into re/im accumulators, with a clear input. Instantiate three times: norm0 (h0 with h0), norm1 (h1 with h1), cross (conj h0 with h1). Norms use only the real output.

Test Plan:
- Unit test: h0 all (1,0), h1 all (0,1), start at cycle 10 -> done at cycle 15; norm0=4, norm1=4, cross_r=0, cross_i=4.
- Ordering/sign test: h0 k0..k3 = (1,2),(3,4),(5,6),(7,8); h1 all (-1,1) -> norm0=204, norm1=8, cross_r=4, cross_i=36.
- Extreme values: every element of both columns = (-32768,-32768) -> norm0=norm1=cross_r=8589934592, cross_i=0; no wrap.
- Busy and back-to-back:
  - Extra start pulses two cycles after the first -> ignored; results match the first input set; exactly one done.
  - Then start again in the done cycle -> second done exactly 6 cycles later with the new results.
- Reset mid-operation: assert rst during CALC idx=2 -> next cycle outputs=0, busy=0, no done. A new start afterwards produces correct results.
- With GRAM_MULT_PIPE_EN defined: repeat the ordering/sign test -> identical results; done at start+6.
